rx_frame_sequencer: RTL and testbench

Receive-side frame controller between the tri-mode Ethernet MAC AXI-Stream RX port and the payload consumer. Sequences a 4-bit header byte counter (0..13, wrap to 0) over the 14-byte Ethernet header, then forwards the payload. Captures destination MAC, source MAC and EtherType, measures payload length, and flags runt, oversize and MAC-bad frames.

---
 rtl/rx_frame_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_rx_frame_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_sequencer.sv
// rx_frame_sequencer: receive-side Ethernet frame controller.
// Walks the 14-byte header with a 4-bit byte counter and captures the
// destination MAC, source MAC and EtherType. The payload is then passed
// straight through to the consumer. At frame end it reports the payload
// length and classifies the frame as good, runt, oversize or MAC-bad.
// Optional feature macro: RX_DA_FILTER_EN. When it is defined, frames whose
// destination is neither LOCAL_MAC nor broadcast are discarded.
module rx_frame_sequencer #(
  parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_01,
  parameter int          MAX_PAYLOAD = 1500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  input  logic        s_tuser,
  output logic        s_tready,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic        hdr_valid,
  output logic [47:0] hdr_dst,
  output logic [47:0] hdr_src,
  output logic [15:0] hdr_type,
  output logic [10:0] pay_len,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        frame_drop
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [10:0] LEN_SAT = 11'd2047;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [103:0]  r_hdr_buf;
  logic [10:0]   r_len;
  logic          r_hdr_valid;
  logic [47:0]   r_hdr_dst;
  logic [47:0]   r_hdr_src;
  logic [15:0]   r_hdr_type;
  logic [10:0]   r_pay_len;
  logic          r_frame_done;
  logic          r_frame_err;
  logic [1:0]    r_err_code;

  logic          w_in_pay;
  logic          w_ready;
  logic          w_accept;
  logic          w_last_hdr;
  logic          w_keep;
  logic [111:0]  w_hdr_full;
  logic [10:0]   w_len_next;
  logic [1:0]    w_pay_code;

  // Ready is held low during reset. Outside PAY the block always accepts
  // bytes. Inside PAY the consumer's ready is passed back upstream.
  assign w_in_pay   = (r_state == PAY);
  assign w_ready    = ~rst & (w_in_pay ? m_tready : 1'b1);
  assign w_accept   = s_tvalid & w_ready;
  assign w_last_hdr = (r_cnt == 4'd13);
  assign w_hdr_full = {r_hdr_buf, s_tdata};
  assign w_len_next = (r_len == LEN_SAT) ? r_len : r_len + 11'd1;

  assign s_tready   = w_ready;
  assign m_tdata    = w_in_pay ? s_tdata : 8'h00;
  assign m_tvalid   = w_in_pay & s_tvalid;
  assign m_tlast    = w_in_pay & s_tlast;

  assign hdr_valid  = r_hdr_valid;
  assign hdr_dst    = r_hdr_dst;
  assign hdr_src    = r_hdr_src;
  assign hdr_type   = r_hdr_type;
  assign pay_len    = r_pay_len;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign err_code   = r_err_code;

  // Error code for a payload frame's last beat. A MAC-bad flag takes
  // priority over the oversize check.
  always_comb begin
    w_pay_code = 2'b00;
    if (s_tuser) begin
      w_pay_code = 2'b11;
    end else if (int'(w_len_next) > MAX_PAYLOAD) begin
      w_pay_code = 2'b10;
    end
  end

`ifdef RX_DA_FILTER_EN
  logic        r_keep;
  logic        r_frame_drop;
  logic [47:0] w_dst_now;

  assign w_dst_now  = {r_hdr_buf[39:0], s_tdata};
  assign w_keep     = r_keep;
  assign frame_drop = r_frame_drop;

  // Decide whether to accept the destination once all six bytes are in.
  // The remaining header bytes are still consumed afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_keep <= 1'b1;
    end else if ((r_state == HDR) && w_accept && (r_cnt == 4'd5)) begin
      r_keep <= (w_dst_now == LOCAL_MAC) || (w_dst_now == 48'hFFFF_FFFF_FFFF);
    end
  end

  // Pulse the drop flag one cycle after the last header byte of a
  // rejected frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_drop <= 1'b0;
    end else begin
      r_frame_drop <= (r_state == HDR) && w_accept && w_last_hdr && !r_keep;
    end
  end
`else
  // Without filtering every frame is kept. The station address is folded
  // into the constant so the parameter stays referenced.
  assign w_keep     = 1'b1 | (|LOCAL_MAC);
  assign frame_drop = 1'b0;
`endif

  // Main sequencer: header counting and capture, payload length tracking,
  // and the registered header and end-of-frame reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_hdr_buf    <= '0;
      r_len        <= 11'd0;
      r_hdr_valid  <= 1'b0;
      r_hdr_dst    <= 48'h0;
      r_hdr_src    <= 48'h0;
      r_hdr_type   <= 16'h0;
      r_pay_len    <= 11'd0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_code   <= 2'b00;
    end else begin
      r_hdr_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_hdr_buf <= {r_hdr_buf[95:0], s_tdata};
            if (s_tlast) begin
              r_frame_done <= 1'b1;
              r_frame_err  <= 1'b1;
              r_err_code   <= 2'b01;
            end else begin
              r_cnt   <= 4'd1;
              r_state <= HDR;
            end
          end
        end
        HDR: begin
          if (w_accept) begin
            r_hdr_buf <= {r_hdr_buf[95:0], s_tdata};
            if (w_last_hdr) begin
              r_cnt <= 4'd0;
              r_len <= 11'd0;
              if (w_keep) begin
                r_hdr_valid <= 1'b1;
                r_hdr_dst   <= w_hdr_full[111:64];
                r_hdr_src   <= w_hdr_full[63:16];
                r_hdr_type  <= w_hdr_full[15:0];
              end
              if (s_tlast) begin
                r_state <= IDLE;
                if (w_keep) begin
                  r_frame_done <= 1'b1;
                  r_frame_err  <= s_tuser;
                  r_err_code   <= s_tuser ? 2'b11 : 2'b00;
                  r_pay_len    <= 11'd0;
                end
              end else begin
                r_state <= w_keep ? PAY : DROP;
              end
            end else if (s_tlast) begin
              r_cnt        <= 4'd0;
              r_state      <= IDLE;
              r_frame_done <= 1'b1;
              r_frame_err  <= 1'b1;
              r_err_code   <= 2'b01;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        PAY: begin
          if (w_accept) begin
            r_len <= w_len_next;
            if (s_tlast) begin
              r_state      <= IDLE;
              r_frame_done <= 1'b1;
              r_frame_err  <= |w_pay_code;
              r_err_code   <= w_pay_code;
              r_pay_len    <= w_len_next;
            end
          end
        end
        DROP: begin
          if (w_accept && s_tlast) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// tb_rx_frame_sequencer: scoreboard bench for rx_frame_sequencer.
// Expected header, payload and end-of-frame results are computed per frame
// from its byte list and queued. A separate monitor compares them with the
// DUT outputs as they appear. Follows RX_DA_FILTER_EN like the design.
`timescale 1ns/1ps
module tb_rx_frame_sequencer;

  localparam logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_01;
  localparam int          MAX_PAYLOAD = 1500;

  logic        clk;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tuser;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic        hdr_valid;
  logic [47:0] hdr_dst;
  logic [47:0] hdr_src;
  logic [15:0] hdr_type;
  logic [10:0] pay_len;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        frame_drop;

  int totalChecks = 0;
  int badChecks   = 0;
  int readyMode   = 0;
  int dropPending = 0;
  int lastPayLen  = 0;

  logic [8:0]   payQ[$];
  logic [111:0] hdrQ[$];
  logic [14:0]  endQ[$];

  rx_frame_sequencer #(
    .LOCAL_MAC  (LOCAL_MAC),
    .MAX_PAYLOAD(MAX_PAYLOAD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tuser   (s_tuser),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .hdr_valid (hdr_valid),
    .hdr_dst   (hdr_dst),
    .hdr_src   (hdr_src),
    .hdr_type  (hdr_type),
    .pay_len   (pay_len),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .err_code  (err_code),
    .frame_drop(frame_drop)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Consumer ready: always on, toggling every cycle, or random
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = ($urandom_range(3) != 0);
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [111:0] act, input logic [111:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit addrAccepted(input logic [47:0] dst);
`ifdef RX_DA_FILTER_EN
    return (dst == LOCAL_MAC) || (dst == 48'hFFFF_FFFF_FFFF);
`else
    return (dst === dst);
`endif
  endfunction

  // Monitor: pops expectations whenever the DUT presents a result
  initial begin
    logic [8:0]   ePay;
    logic [111:0] eHdr;
    logic [14:0]  eEnd;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_tvalid && m_tready) begin
          if (payQ.size() == 0) begin
            checkOutput("unexpected payload beat", {m_tlast, m_tdata}, 112'h1ff_dead);
          end else begin
            ePay = payQ.pop_front();
            checkOutput("payload beat {last,data}", {m_tlast, m_tdata}, ePay);
          end
        end
        if (hdr_valid) begin
          if (hdrQ.size() == 0) begin
            checkOutput("unexpected hdr_valid", 1, 0);
          end else begin
            eHdr = hdrQ.pop_front();
            checkOutput("header {dst,src,type}", {hdr_dst, hdr_src, hdr_type}, eHdr);
          end
        end
        if (frame_done || frame_err) begin
          if (endQ.size() == 0) begin
            checkOutput("unexpected frame end", {frame_done, frame_err, err_code, pay_len}, 0);
          end else begin
            eEnd = endQ.pop_front();
            checkOutput("frame end {done,err,code,len}", {frame_done, frame_err, err_code, pay_len}, eEnd);
          end
        end
        if (frame_drop) begin
          if (dropPending == 0) begin
            checkOutput("unexpected frame_drop", 1, 0);
          end else begin
            dropPending--;
          end
        end
      end
    end
  end

  // Offer one byte, with random stalls, until the DUT accepts it
  task automatic driveByte(input logic [7:0] d, input bit last, input bit user, input int stallPct);
    int  waitCycles = 0;
    bit  done = 1'b0;
    while (!done) begin
      if (int'($urandom_range(99)) < stallPct) begin
        s_tvalid = 1'b0;
        s_tdata  = 8'($urandom);
        s_tlast  = 1'($urandom);
        s_tuser  = 1'($urandom);
      end else begin
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = user;
      end
      @(negedge clk);
      done = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      waitCycles++;
      if (!done && waitCycles > 300) begin
        checkOutput("beat accept timeout", 0, 1);
        done = 1'b1;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Build one frame, queue its expected results, then send it.
  // runtLen > 0 cuts the frame to that many header bytes.
  task automatic applyStimulus(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                               input int payLen, input bit bad, input int runtLen, input int stallPct);
    logic [7:0]   bytes[$];
    logic [111:0] hdr;
    int           n;
    int           satLen;
    logic [1:0]   code;
    hdr = {dst, src, typ};
    for (int i = 0; i < 14; i++) begin
      if (runtLen == 0 || i < runtLen) bytes.push_back(hdr[111-8*i -: 8]);
    end
    if (runtLen == 0) begin
      for (int i = 0; i < payLen; i++) bytes.push_back(8'($urandom));
    end
    n = bytes.size();
    if (n < 14) begin
      endQ.push_back({1'b1, 1'b1, 2'b01, 11'(lastPayLen)});
    end else if (!addrAccepted(dst)) begin
      dropPending++;
    end else begin
      hdrQ.push_back(hdr);
      for (int i = 14; i < n; i++) payQ.push_back({(i == n - 1), bytes[i]});
      satLen = (payLen > 2047) ? 2047 : payLen;
      code   = bad ? 2'b11 : ((payLen > MAX_PAYLOAD) ? 2'b10 : 2'b00);
      endQ.push_back({1'b1, (code != 2'b00), code, 11'(satLen)});
      lastPayLen = satLen;
    end
    for (int i = 0; i < n; i++) begin
      driveByte(bytes[i], (i == n - 1), (i == n - 1) ? bad : 1'($urandom), stallPct);
    end
  endtask

  // Wait, within a bound, for every queued expectation to be consumed
  task automatic waitDrain();
    int cycles = 0;
    while ((payQ.size() != 0 || hdrQ.size() != 0 || endQ.size() != 0 || dropPending != 0) && cycles < 200) begin
      @(posedge clk);
      cycles++;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard drained {pay,hdr,end,drop}",
                {(payQ.size() != 0), (hdrQ.size() != 0), (endQ.size() != 0), (dropPending != 0)}, 0);
  endtask

  task automatic checkAllZero(input string tag);
    @(negedge clk);
    checkOutput({tag, " s_tready"}, s_tready, 0);
    checkOutput({tag, " m_* {valid,last,data}"}, {m_tvalid, m_tlast, m_tdata}, 0);
    checkOutput({tag, " hdr_valid"}, hdr_valid, 0);
    checkOutput({tag, " hdr fields"}, {hdr_dst, hdr_src, hdr_type}, 0);
    checkOutput({tag, " pay_len/err_code"}, {pay_len, err_code}, 0);
    checkOutput({tag, " pulses {done,err,drop}"}, {frame_done, frame_err, frame_drop}, 0);
  endtask

  initial begin
    logic [63:0] r64;
    logic [47:0] rdst;
    rst      = 1'b1;
    s_tdata  = 8'h00;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    repeat (3) @(posedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] good frame");
    readyMode = 0;
    applyStimulus(48'hFFFF_FFFF_FFFF, 48'h00_11_22_33_44_55, 16'h0800, 46, 1'b0, 0, 0);
    $display("[TB] runt then good frame");
    applyStimulus(48'h02_00_00_00_00_01, 48'hAA_BB_CC_DD_EE_FF, 16'h86DD, 0, 1'b0, 10, 0);
    applyStimulus(48'h02_00_00_00_00_01, 48'h10_20_30_40_50_60, 16'h0806, 12, 1'b0, 0, 0);
    applyStimulus(48'hFFFF_FFFF_FFFF, 48'h01_02_03_04_05_06, 16'h0800, 0, 1'b0, 1, 0);
    waitDrain();

    $display("[TB] backpressure with MAC-bad frame");
    readyMode = 1;
    applyStimulus(48'hFFFF_FFFF_FFFF, 48'h66_77_88_99_AA_BB, 16'h0800, 60, 1'b1, 0, 0);
    waitDrain();

    $display("[TB] oversize, saturation, zero payload, back-to-back");
    readyMode = 0;
    applyStimulus(48'h02_00_00_00_00_01, 48'h00_00_00_00_00_0A, 16'h0800, 1501, 1'b0, 0, 0);
    applyStimulus(48'hFFFF_FFFF_FFFF, 48'h00_00_00_00_00_0B, 16'h0801, 20, 1'b0, 0, 0);
    applyStimulus(48'hFFFF_FFFF_FFFF, 48'h00_00_00_00_00_0C, 16'h0802, 0, 1'b0, 0, 0);
    applyStimulus(48'hFFFF_FFFF_FFFF, 48'h00_00_00_00_00_0D, 16'h0803, 1500, 1'b0, 0, 0);
    applyStimulus(48'hFFFF_FFFF_FFFF, 48'h00_00_00_00_00_0E, 16'h0804, 2100, 1'b0, 0, 0);
    applyStimulus(48'hFFFF_FFFF_FFFF, 48'h00_00_00_00_00_0F, 16'h0805, 0, 1'b1, 0, 0);
    waitDrain();

    $display("[TB] destination filter frames");
    applyStimulus(48'h02_00_00_00_00_02, 48'h00_00_00_00_00_21, 16'h0800, 30, 1'b0, 0, 0);
    applyStimulus(48'h02_00_00_00_00_01, 48'h00_00_00_00_00_22, 16'h0800, 30, 1'b0, 0, 0);
    applyStimulus(48'h02_00_00_00_00_03, 48'h00_00_00_00_00_23, 16'h0800, 0, 1'b0, 0, 0);
    applyStimulus(48'h02_00_00_00_00_04, 48'h00_00_00_00_00_24, 16'h0800, 0, 1'b0, 9, 0);
    waitDrain();

    $display("[TB] randomized frames");
    readyMode = 2;
    for (int f = 0; f < 30; f++) begin
      r64 = {$urandom, $urandom};
      case ($urandom_range(2))
        0:       rdst = LOCAL_MAC;
        1:       rdst = 48'hFFFF_FFFF_FFFF;
        default: rdst = r64[47:0];
      endcase
      r64 = {$urandom, $urandom};
      applyStimulus(rdst, r64[47:0], 16'($urandom), int'($urandom_range(70)), 1'($urandom_range(3) == 0),
                    ($urandom_range(4) == 0) ? int'($urandom_range(13, 1)) : 0, 30);
    end
    waitDrain();

    $display("[TB] reset mid-frame");
    readyMode = 0;
    for (int i = 0; i < 8; i++) driveByte(8'(8'hA0 + i), 1'b0, 1'b0, 0);
    rst = 1'b1;
    lastPayLen = 0;
    checkAllZero("mid-frame reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(48'h02_00_00_00_00_01, 48'hDE_AD_BE_EF_00_01, 16'h0800, 25, 1'b0, 0, 0);
    applyStimulus(48'hFFFF_FFFF_FFFF, 48'hDE_AD_BE_EF_00_02, 16'h0800, 0, 1'b0, 5, 0);
    waitDrain();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
